// File: rtl/serv_csr_mirq_if.sv
// CSR select/data bus between the SERV decoder/register-file side and serv_csr_mirq.
// W is the serial beat width and must match the attached serv_csr_mirq instance.
interface serv_csr_mirq_if #(
  parameter int W = 1
);
  logic         i_mstatus_en;
  logic         i_mie_en;
  logic         i_mip_en;
  logic         i_mcause_en;
  logic [1:0]   i_csr_source;
  logic         i_csr_d_sel;
  logic [W-1:0] i_rf_csr_out;
  logic [W-1:0] i_csr_imm;
  logic [W-1:0] i_rs1;
  logic [W-1:0] o_csr_in;
  logic [W-1:0] o_q;

  modport master (
    output i_mstatus_en, i_mie_en, i_mip_en, i_mcause_en,
    output i_csr_source, i_csr_d_sel, i_rf_csr_out, i_csr_imm, i_rs1,
    input  o_csr_in, o_q
  );

  modport slave (
    input  i_mstatus_en, i_mie_en, i_mip_en, i_mcause_en,
    input  i_csr_source, i_csr_d_sel, i_rf_csr_out, i_csr_imm, i_rs1,
    output o_csr_in, o_q
  );
endinterface

// File: rtl/serv_csr_mirq.sv
// Bit-serial machine-mode CSR unit with msip/mtip/meip interrupt sources and W-bit beats.
// Optional feature macro SERV_CSR_MPIE_RW_EN: mstatus.MPIE readable/writable, mret sets it.
module serv_csr_mirq #(
  parameter        RESET_STRATEGY = "MINI",
  parameter int    W = 1,
  parameter int    B = W - 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_init,
  input  logic           i_en,
  input  logic           i_cnt0to3,
  input  logic           i_cnt3,
  input  logic           i_cnt7,
  input  logic           i_cnt11,
  input  logic           i_cnt_done,
  input  logic           i_mem_op,
  input  logic           i_mem_cmd,
  input  logic           i_e_op,
  input  logic           i_ebreak,
  input  logic           i_trap,
  input  logic           i_mret,
  input  logic [2:0]     i_irq,
  serv_csr_mirq_if.slave csr,
  output logic           o_new_irq
);
  localparam bit          RST_EN = (RESET_STRATEGY != "NONE");
  localparam int unsigned L3  = 3 % W;
  localparam int unsigned L7  = 7 % W;
  localparam int unsigned L11 = 11 % W;

  logic [B:0] csr_out;
  logic [B:0] csr_d;
  logic [B:0] csr_in;
  logic [B:0] mcause_rd;
  logic [7:0] mcause_pad;
  logic [7:0] csr_in_pad;
  logic [2:0] pending;
  logic [2:0] new_src;
  logic [3:0] exc_code;
  logic       trap_done;

  logic       mstatus_mie_q, mstatus_mie_d;
  logic       mpie_q, mpie_d;
  logic [2:0] mie_q, mie_d;
  logic [2:0] irq_r_q, irq_r_d;
  logic       new_irq_q, new_irq_d;
  logic [3:0] irq_code_q, irq_code_d;
  logic [3:0] mcause_lo_q, mcause_lo_d;
  logic       mcause31_q, mcause31_d;

  assign mcause_pad = {4'b0000, mcause_lo_q};
  assign csr_in_pad = 8'(csr_in);

  // With W=1 the low mcause nibble is a rotating shift register; wider beats expose it on beat 0.
  always_comb begin
    mcause_rd = '0;
    if (W == 1) mcause_rd[0] = mcause_lo_q[0];
    else        mcause_rd    = mcause_pad[B:0];
  end

  always_comb begin
    csr_out = csr.i_rf_csr_out;
    if (csr.i_mstatus_en & i_en & i_cnt3) csr_out[L3] = csr_out[L3] | mstatus_mie_q;
`ifdef SERV_CSR_MPIE_RW_EN
    if (csr.i_mstatus_en & i_en & i_cnt7) csr_out[L7] = csr_out[L7] | mpie_q;
`endif
    if (csr.i_mie_en & i_en & i_cnt3)  csr_out[L3]  = csr_out[L3]  | mie_q[0];
    if (csr.i_mie_en & i_en & i_cnt7)  csr_out[L7]  = csr_out[L7]  | mie_q[1];
    if (csr.i_mie_en & i_en & i_cnt11) csr_out[L11] = csr_out[L11] | mie_q[2];
    if (csr.i_mip_en & i_en & i_cnt3)  csr_out[L3]  = csr_out[L3]  | i_irq[0];
    if (csr.i_mip_en & i_en & i_cnt7)  csr_out[L7]  = csr_out[L7]  | i_irq[1];
    if (csr.i_mip_en & i_en & i_cnt11) csr_out[L11] = csr_out[L11] | i_irq[2];
    if (csr.i_mcause_en & i_en & i_cnt0to3)  csr_out = csr_out | mcause_rd;
    if (csr.i_mcause_en & i_en & i_cnt_done) csr_out[B] = csr_out[B] | mcause31_q;
  end

  always_comb begin
    csr_d = csr.i_csr_d_sel ? csr.i_csr_imm : csr.i_rs1;
    unique case (csr.i_csr_source)
      2'b01:   csr_in = csr_d;
      2'b10:   csr_in = csr_out | csr_d;
      2'b11:   csr_in = csr_out & ~csr_d;
      default: csr_in = csr_out;
    endcase
  end

  assign csr.o_csr_in = csr_in;
  assign csr.o_q      = csr_out;
  assign o_new_irq    = new_irq_q;

  always_comb begin
    if (i_e_op)        exc_code = i_ebreak ? 4'b0011 : 4'b1011;
    else if (i_mem_op) exc_code = i_mem_cmd ? 4'b0110 : 4'b0100;
    else               exc_code = 4'b0000;
  end

  always_comb begin
    pending    = i_irq & mie_q & {3{mstatus_mie_q}};
    new_src    = pending & ~irq_r_q;
    trap_done  = i_trap & i_cnt_done;
    irq_r_d    = irq_r_q;
    new_irq_d  = new_irq_q;
    irq_code_d = irq_code_q;
    if (!i_init & i_cnt_done) begin
      irq_r_d   = pending;
      new_irq_d = |new_src;
      if (new_src[2])      irq_code_d = 4'b1011;
      else if (new_src[0]) irq_code_d = 4'b0011;
      else if (new_src[1]) irq_code_d = 4'b0111;
    end

    mie_d = mie_q;
    if (csr.i_mie_en & i_en) begin
      if (i_cnt3)  mie_d[0] = csr_in[L3];
      if (i_cnt7)  mie_d[1] = csr_in[L7];
      if (i_cnt11) mie_d[2] = csr_in[L11];
    end

    mstatus_mie_d = mstatus_mie_q;
    if (trap_done)                                 mstatus_mie_d = 1'b0;
    else if (i_mret)                               mstatus_mie_d = mpie_q;
    else if (csr.i_mstatus_en & i_cnt3 & i_en)     mstatus_mie_d = csr_in[L3];

    mpie_d = mpie_q;
    if (trap_done)                                 mpie_d = mstatus_mie_q;
`ifdef SERV_CSR_MPIE_RW_EN
    else if (i_mret)                               mpie_d = 1'b1;
    else if (csr.i_mstatus_en & i_cnt7 & i_en)     mpie_d = csr_in[L7];
`endif

    mcause_lo_d = mcause_lo_q;
    mcause31_d  = mcause31_q;
    if (trap_done) begin
      mcause31_d  = new_irq_q;
      mcause_lo_d = new_irq_q ? irq_code_q : exc_code;
    end else begin
      if (csr.i_mcause_en & i_en & i_cnt0to3)
        mcause_lo_d = (W == 1) ? {csr_in_pad[0], mcause_lo_q[3:1]} : csr_in_pad[3:0];
      if (csr.i_mcause_en & i_cnt_done) mcause31_d = csr_in[B];
    end
  end

  always_ff @(posedge i_clk) begin
    if (RST_EN && i_rst) begin
      mstatus_mie_q <= 1'b0;
      mie_q         <= '0;
      irq_r_q       <= '0;
      new_irq_q     <= 1'b0;
    end else begin
      mstatus_mie_q <= mstatus_mie_d;
      mie_q         <= mie_d;
      irq_r_q       <= irq_r_d;
      new_irq_q     <= new_irq_d;
    end
  end

  always_ff @(posedge i_clk) begin
    mpie_q      <= mpie_d;
    irq_code_q  <= irq_code_d;
    mcause_lo_q <= mcause_lo_d;
    mcause31_q  <= mcause31_d;
  end
endmodule

// File: tb/tb_serv_csr_mirq.sv
// Directed bench for serv_csr_mirq: W=1, 4 and 8 instances driven one at a time with
// whole 32-bit serial CSR instructions; expected values are hand-computed constants.
module tb_serv_csr_mirq;
`ifdef SERV_CSR_MPIE_RW_EN
  localparam bit MPIE_RW = 1'b1;
`else
  localparam bit MPIE_RW = 1'b0;
`endif
  localparam logic [3:0] S_NONE = 4'b0000, S_MSTATUS = 4'b1000, S_MIE = 4'b0100,
                         S_MIP = 4'b0010, S_MCAUSE = 4'b0001;
  localparam logic [1:0] SRC_CSR = 2'b00, SRC_EXT = 2'b01, SRC_SET = 2'b10;
  // ctx bits: {e_op, ebreak, mem_op, mem_cmd}
  localparam logic [3:0] C_NONE = 4'b0000, C_ECALL = 4'b1000, C_EBREAK = 4'b1100,
                         C_LOAD = 4'b0010, C_STORE = 4'b0011;

  logic       clk = 1'b0;
  logic       rst;
  logic       init, en, cnt0to3, cnt3, cnt7, cnt11, cnt_done;
  logic       mem_op, mem_cmd, e_op, ebreak, trap, mret;
  logic [2:0] irq, dut_sel, new_irq;
  logic       mstatus_en, mie_en, mip_en, mcause_en, d_sel;
  logic [1:0] src;
  logic [7:0] rf_v, imm_v, rs1_v;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  serv_csr_mirq_if #(.W(1)) if1 ();
  serv_csr_mirq_if #(.W(4)) if4 ();
  serv_csr_mirq_if #(.W(8)) if8 ();

  assign if1.i_mstatus_en = mstatus_en; assign if1.i_mie_en = mie_en;
  assign if1.i_mip_en = mip_en;         assign if1.i_mcause_en = mcause_en;
  assign if1.i_csr_source = src;        assign if1.i_csr_d_sel = d_sel;
  assign if1.i_rf_csr_out = rf_v[0:0];  assign if1.i_csr_imm = imm_v[0:0];
  assign if1.i_rs1 = rs1_v[0:0];
  assign if4.i_mstatus_en = mstatus_en; assign if4.i_mie_en = mie_en;
  assign if4.i_mip_en = mip_en;         assign if4.i_mcause_en = mcause_en;
  assign if4.i_csr_source = src;        assign if4.i_csr_d_sel = d_sel;
  assign if4.i_rf_csr_out = rf_v[3:0];  assign if4.i_csr_imm = imm_v[3:0];
  assign if4.i_rs1 = rs1_v[3:0];
  assign if8.i_mstatus_en = mstatus_en; assign if8.i_mie_en = mie_en;
  assign if8.i_mip_en = mip_en;         assign if8.i_mcause_en = mcause_en;
  assign if8.i_csr_source = src;        assign if8.i_csr_d_sel = d_sel;
  assign if8.i_rf_csr_out = rf_v;       assign if8.i_csr_imm = imm_v;
  assign if8.i_rs1 = rs1_v;

  serv_csr_mirq #(.RESET_STRATEGY("MINI"), .W(1)) u_w1 (
    .i_clk(clk), .i_rst(rst), .i_init(init), .i_en(en & dut_sel[0]),
    .i_cnt0to3(cnt0to3), .i_cnt3(cnt3), .i_cnt7(cnt7), .i_cnt11(cnt11),
    .i_cnt_done(cnt_done & dut_sel[0]), .i_mem_op(mem_op), .i_mem_cmd(mem_cmd),
    .i_e_op(e_op), .i_ebreak(ebreak), .i_trap(trap), .i_mret(mret & dut_sel[0]),
    .i_irq(irq), .csr(if1), .o_new_irq(new_irq[0]));

  serv_csr_mirq #(.RESET_STRATEGY("MINI"), .W(4)) u_w4 (
    .i_clk(clk), .i_rst(rst), .i_init(init), .i_en(en & dut_sel[1]),
    .i_cnt0to3(cnt0to3), .i_cnt3(cnt3), .i_cnt7(cnt7), .i_cnt11(cnt11),
    .i_cnt_done(cnt_done & dut_sel[1]), .i_mem_op(mem_op), .i_mem_cmd(mem_cmd),
    .i_e_op(e_op), .i_ebreak(ebreak), .i_trap(trap), .i_mret(mret & dut_sel[1]),
    .i_irq(irq), .csr(if4), .o_new_irq(new_irq[1]));

  serv_csr_mirq #(.RESET_STRATEGY("MINI"), .W(8)) u_w8 (
    .i_clk(clk), .i_rst(rst), .i_init(init), .i_en(en & dut_sel[2]),
    .i_cnt0to3(cnt0to3), .i_cnt3(cnt3), .i_cnt7(cnt7), .i_cnt11(cnt11),
    .i_cnt_done(cnt_done & dut_sel[2]), .i_mem_op(mem_op), .i_mem_cmd(mem_cmd),
    .i_e_op(e_op), .i_ebreak(ebreak), .i_trap(trap), .i_mret(mret & dut_sel[2]),
    .i_irq(irq), .csr(if8), .o_new_irq(new_irq[2]));

  function automatic int wid(input int k);
    return (k == 0) ? 1 : (k == 1) ? 4 : 8;
  endfunction

  task automatic idle();
    {init, en, cnt0to3, cnt3, cnt7, cnt11, cnt_done} = '0;
    {mem_op, mem_cmd, e_op, ebreak, trap, mret} = '0;
    {mstatus_en, mie_en, mip_en, mcause_en, d_sel} = '0;
    src = SRC_CSR; rf_v = '0; imm_v = '0; rs1_v = '0; dut_sel = '0;
  endtask

  // One full instruction on instance k; the unselected operand carries inverted data.
  task automatic run_instr(input int k, input logic [3:0] csel, input logic [1:0] s,
                           input logic ds, input logic [31:0] dv, input logic tr,
                           input logic mr, input logic [3:0] ctx, output logic [31:0] rd);
    int w, beats;
    logic [31:0] sh, m;
    logic [7:0] q;
    w = wid(k); beats = 32 / w; m = (32'd1 << w) - 32'd1;
    dut_sel = 3'b001 << k;
    {mstatus_en, mie_en, mip_en, mcause_en} = csel;
    src = s; d_sel = ds; trap = tr; en = 1'b1; init = 1'b0;
    {e_op, ebreak, mem_op, mem_cmd} = ctx;
    rd = '0;
    for (int b = 0; b < beats; b++) begin
      cnt0to3 = (b * w < 4); cnt3 = (b == 3 / w); cnt7 = (b == 7 / w);
      cnt11 = (b == 11 / w); cnt_done = (b == beats - 1);
      mret = mr & cnt_done;
      sh = dv >> (b * w);
      if (ds) begin imm_v = sh[7:0]; rs1_v = ~sh[7:0]; end
      else    begin rs1_v = sh[7:0]; imm_v = ~sh[7:0]; end
      @(negedge clk);
      q = (k == 0) ? {7'b0, if1.o_q} : (k == 1) ? {4'b0, if4.o_q} : if8.o_q;
      rd = rd | ((32'(q) & m) << (b * w));
      @(posedge clk); #1;
    end
    idle();
  endtask

  task automatic rd_csr(input int k, input logic [3:0] csel, output logic [31:0] rd);
    run_instr(k, csel, SRC_SET, 1'b0, 32'h0, 1'b0, 1'b0, C_NONE, rd);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    idle(); irq = 3'b000; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (new_irq[k] !== 1'b0) begin
        $display("FAIL reset_new_irq w%0d got=%b exp=0", wid(k), new_irq[k]); errors++;
      end
      rd_csr(k, S_MSTATUS, rd);
      checks++;  // MPIE has no reset value, so bit 7 is excluded here
      if ((rd & 32'hFFFF_FF7F) !== 32'h0) begin
        $display("FAIL reset_mstatus w%0d got=0x%08h exp=0x00000000", wid(k), rd); errors++;
      end
      rd_csr(k, S_MIE, rd);
      checks++;
      if (rd !== 32'h0) begin
        $display("FAIL reset_mie w%0d got=0x%08h exp=0x00000000", wid(k), rd); errors++;
      end
      rd_csr(k, S_MIP, rd);
      checks++;
      if (rd !== 32'h0) begin
        $display("FAIL reset_mip w%0d got=0x%08h exp=0x00000000", wid(k), rd); errors++;
      end
    end
  endtask

  task automatic test_mie_set(input int k);
    logic [31:0] rd;
    run_instr(k, S_MIE, SRC_SET, 1'b1, 32'h080, 1'b0, 1'b0, C_NONE, rd);
    checks++;
    if (rd !== 32'h0) begin
      $display("FAIL mie_csrrs_old w%0d got=0x%08h exp=0x00000000", wid(k), rd); errors++;
    end
    rd_csr(k, S_MIE, rd);
    checks++;
    if (rd !== 32'h080) begin
      $display("FAIL mie_readback w%0d got=0x%08h exp=0x00000080", wid(k), rd); errors++;
    end
  endtask

  task automatic test_mip_readonly(input int k);
    logic [31:0] rd;
    irq = 3'b101;
    run_instr(k, S_MIP, SRC_EXT, 1'b1, 32'hFFF, 1'b0, 1'b0, C_NONE, rd);
    checks++;
    if (rd !== 32'h808) begin
      $display("FAIL mip_csrrw_old w%0d got=0x%08h exp=0x00000808", wid(k), rd); errors++;
    end
    rd_csr(k, S_MIP, rd);
    checks++;
    if (rd !== 32'h808) begin
      $display("FAIL mip_readonly w%0d got=0x%08h exp=0x00000808", wid(k), rd); errors++;
    end
    irq = 3'b000;
  endtask

  task automatic test_timer_irq(input int k);
    logic [31:0] rd;
    irq = 3'b000;
    run_instr(k, S_MSTATUS, SRC_SET, 1'b0, 32'h8, 1'b0, 1'b0, C_NONE, rd);
    run_instr(k, S_MIE, SRC_EXT, 1'b0, 32'h888, 1'b0, 1'b0, C_NONE, rd);
    irq = 3'b010;
    run_instr(k, S_NONE, SRC_CSR, 1'b0, 32'h0, 1'b0, 1'b0, C_NONE, rd);
    checks++;
    if (new_irq[k] !== 1'b1) begin
      $display("FAIL timer_new_irq w%0d got=%b exp=1", wid(k), new_irq[k]); errors++;
    end
    run_instr(k, S_NONE, SRC_CSR, 1'b0, 32'h0, 1'b1, 1'b0, C_NONE, rd);
    checks++;
    if (new_irq[k] !== 1'b0) begin
      $display("FAIL timer_held_level w%0d got=%b exp=0", wid(k), new_irq[k]); errors++;
    end
    rd_csr(k, S_MCAUSE, rd);
    checks++;
    if (rd !== 32'h8000_0007) begin
      $display("FAIL timer_mcause w%0d got=0x%08h exp=0x80000007", wid(k), rd); errors++;
    end
    rd_csr(k, S_MSTATUS, rd);
    checks++;
    if (rd !== (MPIE_RW ? 32'h80 : 32'h00)) begin
      $display("FAIL timer_mstatus w%0d got=0x%08h exp=0x%08h", wid(k), rd,
               MPIE_RW ? 32'h80 : 32'h00);
      errors++;
    end
  endtask

  task automatic test_ext_priority(input int k);
    logic [31:0] rd;
    irq = 3'b000;
    run_instr(k, S_MSTATUS, SRC_SET, 1'b0, 32'h8, 1'b0, 1'b0, C_NONE, rd);
    irq = 3'b101;
    run_instr(k, S_NONE, SRC_CSR, 1'b0, 32'h0, 1'b0, 1'b0, C_NONE, rd);
    checks++;
    if (new_irq[k] !== 1'b1) begin
      $display("FAIL ext_new_irq w%0d got=%b exp=1", wid(k), new_irq[k]); errors++;
    end
    run_instr(k, S_NONE, SRC_CSR, 1'b0, 32'h0, 1'b1, 1'b0, C_NONE, rd);
    checks++;
    if (new_irq[k] !== 1'b0) begin
      $display("FAIL ext_held_level w%0d got=%b exp=0", wid(k), new_irq[k]); errors++;
    end
    rd_csr(k, S_MCAUSE, rd);
    checks++;
    if (rd !== 32'h8000_000B) begin
      $display("FAIL ext_mcause w%0d got=0x%08h exp=0x8000000B", wid(k), rd); errors++;
    end
    irq = 3'b000;
  endtask

  task automatic test_exceptions(input int k);
    logic [31:0] rd;
    logic [3:0]  ctxs [4];
    logic [31:0] exps [4];
    ctxs = '{C_ECALL, C_EBREAK, C_LOAD, C_STORE};
    exps = '{32'h0000_000B, 32'h0000_0003, 32'h0000_0004, 32'h0000_0006};
    for (int i = 0; i < 4; i++) begin
      run_instr(k, S_NONE, SRC_CSR, 1'b0, 32'h0, 1'b1, 1'b0, ctxs[i], rd);
      rd_csr(k, S_MCAUSE, rd);
      checks++;
      if (rd !== exps[i]) begin
        $display("FAIL exc_mcause_%0d w%0d got=0x%08h exp=0x%08h", i, wid(k), rd, exps[i]);
        errors++;
      end
    end
  endtask

  task automatic test_mpie(input int k);
    logic [31:0] rd;
    run_instr(k, S_MSTATUS, SRC_EXT, 1'b0, 32'h80, 1'b0, 1'b0, C_NONE, rd);
    run_instr(k, S_NONE, SRC_CSR, 1'b0, 32'h0, 1'b0, 1'b1, C_NONE, rd);
    rd_csr(k, S_MSTATUS, rd);
    checks++;
    if (rd !== (MPIE_RW ? 32'h88 : 32'h00)) begin
      $display("FAIL mpie_mret_mstatus w%0d got=0x%08h exp=0x%08h", wid(k), rd,
               MPIE_RW ? 32'h88 : 32'h00);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    for (int k = 0; k < 3; k++) begin
      test_mie_set(k);
      test_mip_readonly(k);
      test_timer_irq(k);
      test_ext_priority(k);
      test_exceptions(k);
      test_mpie(k);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
